// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the memory-stage request/response interface.
// Holds the responder state encoding, parameter defaults and line-offset math.
package mem_if_pkg;

    localparam int unsigned LINE_WORDS_DEF = 4;
    localparam int unsigned LATENCY_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        WACK  = 2'd3
    } state_t;

    // Word offset k beats after the critical word, wrapping inside a power-of-2 line.
    function automatic int unsigned wrap_offset(input int unsigned crit,
                                                input int unsigned k,
                                                input int unsigned line_words);
        return (crit + k) & (line_words - 1);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage with synchronous read and synchronous write.
// Contents are deliberately not reset; rdata holds its value while en is low.
module mem_array #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Backing-memory responder for the data cache: single-word write-through with ack,
// or critical-word-first line fill, each after a fixed access latency.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LINE_WORDS  = LINE_WORDS_DEF,
    parameter int unsigned LATENCY     = LATENCY_DEF,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [DATA_W-1:0]             resp_data,
    output logic                          resp_last,
    output logic [$clog2(LINE_WORDS)-1:0] resp_word
);

    localparam int unsigned OW = $clog2(LINE_WORDS);
    localparam int unsigned IW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              we_q;
    logic [IW-1:0]     word_q;
    logic [DATA_W-1:0] wdata_q;
    logic              capture;

    logic [DATA_W-1:0] resp_data_n;
    logic [OW-1:0]     resp_word_n;
    logic              resp_last_n;

    logic              mem_en;
    logic              mem_we;
    logic [IW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    logic [IW-1:0]     req_idx;
    logic [OW-1:0]     crit;
    logic [IW-OW-1:0]  line_base;
    logic [OW-1:0]     next_word;
    logic [OW-1:0]     last_word;
    logic              unused_addr;

    assign req_idx     = req_addr[2 +: IW];
    assign crit        = word_q[OW-1:0];
    assign line_base   = word_q[IW-1:OW];
    assign next_word   = OW'(wrap_offset(32'(resp_word), 1, LINE_WORDS));
    assign last_word   = OW'(wrap_offset(32'(crit), LINE_WORDS - 1, LINE_WORDS));
    assign unused_addr = ^{req_addr[ADDR_W-1:IW+2], req_addr[1:0]};

    mem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    // The critical word is read on the accept edge and held through WAIT; every beat
    // hand-off loads the prefetched word and launches the read of the one after it.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        resp_data_n = resp_data;
        resp_word_n = resp_word;
        resp_last_n = resp_last;
        capture     = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = word_q;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    capture  = 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = req_idx;
                    state_n  = WAIT;
                    cnt_n    = CW'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    mem_en      = 1'b1;
                    resp_word_n = crit;
                    if (we_q) begin
                        mem_we      = 1'b1;
                        state_n     = WACK;
                        resp_data_n = '0;
                        resp_last_n = 1'b1;
                    end else begin
                        mem_addr    = {line_base, OW'(wrap_offset(32'(crit), 1, LINE_WORDS))};
                        state_n     = BURST;
                        resp_data_n = mem_rdata;
                        resp_last_n = 1'b0;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            BURST: begin
                if (resp_ready) begin
                    if (resp_last) begin
                        state_n     = IDLE;
                        resp_data_n = '0;
                        resp_word_n = '0;
                        resp_last_n = 1'b0;
                    end else begin
                        mem_en      = 1'b1;
                        mem_addr    = {line_base, OW'(wrap_offset(32'(resp_word), 2, LINE_WORDS))};
                        resp_data_n = mem_rdata;
                        resp_word_n = next_word;
                        resp_last_n = (next_word == last_word);
                    end
                end
            end
            WACK: begin
                if (resp_ready) begin
                    state_n     = IDLE;
                    resp_data_n = '0;
                    resp_word_n = '0;
                    resp_last_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            word_q     <= '0;
            wdata_q    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_word  <= '0;
            resp_last  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            req_ready  <= (state_n == IDLE);
            resp_valid <= (state_n == BURST) || (state_n == WACK);
            resp_data  <= resp_data_n;
            resp_word  <= resp_word_n;
            resp_last  <= resp_last_n;
            if (capture) begin
                we_q    <= req_we;
                word_q  <= req_idx;
                wdata_q <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a table of write/fill transactions with
// hand-computed beats, plus hand sequences for held requests and mid-WAIT reset.
module tb_mem_responder;

    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_last;
    logic [1:0]  resp_word;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    mem_responder #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .LINE_WORDS  (4),
        .LATENCY     (LAT),
        .DEPTH_WORDS (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_last  (resp_last),
        .resp_word  (resp_word)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic            we;
        logic [31:0]     addr;
        logic [31:0]     wdata;
        int              nb;
        logic [3:0][31:0] d;
        logic [3:0][1:0]  w;
        logic [7:0]      rdy;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input int nb,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [1:0] w0, input logic [1:0] w1,
                                input logic [1:0] w2, input logic [1:0] w3,
                                input logic [7:0] rdy);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.nb = nb;
        v.d = {d3, d2, d1, d0};
        v.w = {w3, w2, w1, w0};
        v.rdy = rdy;
        return v;
    endfunction

    // Called at a negedge; returns with the request accepted and acc = accept edge index.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int acc);
        int w;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        w = 0;
        while (!req_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
        @(negedge clk);
        acc = cyc;
        req_valid = 1'b0;
    endtask

    // Collects nb beats, driving resp_ready from rdy bit by bit and checking every sample.
    task automatic recv(input int nb, input logic [3:0][31:0] d, input logic [3:0][1:0] w,
                        input logic [7:0] rdy, input int acc);
        int wt, k, idx;
        logic r;
        wt = 0;
        while (!resp_valid && wt < 40) begin
            @(negedge clk);
            wt++;
        end
        chk("first_beat_latency", 32'(cyc - acc), 32'(LAT));
        k = 0;
        idx = 0;
        while (k < nb && idx < 40 && resp_valid) begin
            r = rdy[idx % 8];
            resp_ready = r;
            chk("beat_valid", 32'(resp_valid), 32'd1);
            chk("beat_data", resp_data, d[k]);
            chk("beat_word", 32'(resp_word), 32'(w[k]));
            chk("beat_last", 32'(resp_last), 32'(k == nb - 1));
            chk("busy_not_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            if (r) k++;
            idx++;
        end
        resp_ready = 1'b0;
        chk("beats_done", 32'(k), 32'(nb));
        chk("valid_drop", 32'(resp_valid), 32'd0);
        chk("ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int acc;
        int c0;

        vecs[0]  = mk(1, 32'h10, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        vecs[1]  = mk(1, 32'h00, 32'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        vecs[2]  = mk(1, 32'h04, 32'd2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'hFF);
        vecs[3]  = mk(1, 32'h08, 32'd3, 1, 0, 0, 0, 0, 2, 0, 0, 0, 8'hFF);
        vecs[4]  = mk(1, 32'h0C, 32'd4, 1, 0, 0, 0, 0, 3, 0, 0, 0, 8'hFF);
        vecs[5]  = mk(1, 32'h20, 32'h1234, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        vecs[6]  = mk(1, 32'h24, 32'h2424, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'hFF);
        vecs[7]  = mk(1, 32'h28, 32'h2828, 1, 0, 0, 0, 0, 2, 0, 0, 0, 8'hFF);
        vecs[8]  = mk(1, 32'h2C, 32'h2C2C, 1, 0, 0, 0, 0, 3, 0, 0, 0, 8'hFF);
        vecs[9]  = mk(0, 32'h08, 32'h0, 4, 3, 4, 1, 2, 2, 3, 0, 1, 8'hFF);
        vecs[10] = mk(0, 32'h08, 32'h0, 4, 3, 4, 1, 2, 2, 3, 0, 1, 8'b1001_1001);
        vecs[11] = mk(0, 32'h1000, 32'h0, 4, 1, 2, 3, 4, 0, 1, 2, 3, 8'hFF);
        vecs[12] = mk(1, 32'h04, 32'h55, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'b1111_1000);
        vecs[13] = mk(0, 32'h04, 32'h0, 4, 32'h55, 3, 4, 1, 1, 2, 3, 0, 8'hFF);
        vecs[14] = mk(1, 32'h2000_0000, 32'h77, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        vecs[15] = mk(0, 32'h0C, 32'h0, 4, 4, 32'h77, 32'h55, 3, 3, 0, 1, 2, 8'hFF);

        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_last", 32'(resp_last), 32'd0);
        chk("rst_resp_word", 32'(resp_word), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata, acc);
            recv(vecs[i].nb, vecs[i].d, vecs[i].w, vecs[i].rdy, acc);
        end

        // Second request held during a fill is taken only after the last beat.
        send(1'b0, 32'h08, 32'h0, acc);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h00; req_wdata = '0;
        recv(4, {32'h55, 32'h77, 32'd4, 32'd3}, {2'd1, 2'd0, 2'd3, 2'd2}, 8'hFF, acc);
        c0 = cyc;
        send(1'b0, 32'h00, 32'h0, acc);
        chk("held_accept_cycle", 32'(acc), 32'(c0 + 1));
        recv(4, {32'd4, 32'd3, 32'h55, 32'h77}, {2'd3, 2'd2, 2'd1, 2'd0}, 8'hFF, acc);

        // Reset in the middle of a write's latency drops the write.
        send(1'b1, 32'h20, 32'hBAD0BAD0, acc);
        @(negedge clk);
        chk("wait_busy", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_resp_data", resp_data, 32'd0);
        chk("midrst_resp_last", 32'(resp_last), 32'd0);
        chk("midrst_resp_word", 32'(resp_word), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        chk("after_rst_no_ack", 32'(resp_valid), 32'd0);
        send(1'b0, 32'h20, 32'h0, acc);
        recv(4, {32'h2C2C, 32'h2828, 32'h2424, 32'h1234}, {2'd3, 2'd2, 2'd1, 2'd0}, 8'hFF, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Backing-memory responder serving the data cache in the pipeline's memory stage. Accepts one request at a time from the cache-side initiator: either a single-word write-through or a cache-line fill. After a programmable access latency it returns a write acknowledge or a critical-word-first burst of line words. It is the memory end of the request/response interface whose initiator raises the memory stage's busy/stall.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, word width; byte addresses are word-aligned (addr[1:0] ignored)
- LINE_WORDS, 4, words per cache line; power of 2, >= 2
- LATENCY, 4, cycles from request accept to first response beat; >= 1
- DEPTH_WORDS, 1024, storage depth in words; power of 2

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1 = single-word write, 0 = line fill
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  response beat present
- resp_ready  in  1  initiator accepts beat
- resp_data  out  DATA_W  read word; 0 on write ack
- resp_last  out  1  final beat of the response
- resp_word  out  log2(LINE_WORDS)  word index within line of current beat

## Operation
- States: IDLE, WAIT, BURST, WACK.
- IDLE: req_ready=1. On req_valid&req_ready the responder captures we, word index = addr[2+:log2(DEPTH_WORDS)], and wdata, then goes to WAIT with cnt=LATENCY-1.
- WAIT: cnt decrements each cycle. When cnt==0, go to BURST if read or WACK if write. Writes commit to storage on the WAIT->WACK transition.
- BURST: beat k (0..LINE_WORDS-1) returns the word at line base + ((crit + k) mod LINE_WORDS), where crit = captured word's low log2(LINE_WORDS) bits (critical-word-first, wrapping within the line). resp_word = that offset. A beat advances only on resp_valid&resp_ready. resp_last=1 on beat LINE_WORDS-1. Acceptance of the last beat returns to IDLE.
- WACK: resp_valid=1, resp_last=1, resp_data=0, resp_word=captured offset. Acceptance returns to IDLE.
- Storage address wraps modulo DEPTH_WORDS; high address bits are ignored.
- resp_ready low holds resp_data, resp_word and resp_last stable; no beat is lost or skipped.
- req_valid outside IDLE is ignored (req_ready=0). A new request may be accepted in the cycle after the last beat is accepted.
- Reset asserted at any time: state goes to IDLE and an in-flight request is discarded. A write not yet committed is dropped. Storage contents are not reset.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_data=0, resp_last=0, resp_word=0.
- Accept at edge T: resp_valid rises after edge T+LATENCY. With resp_ready held high, a fill returns LINE_WORDS beats on consecutive cycles.
- Read data comes from synchronous-read storage. The next beat's word is prefetched so back-to-back beats have no bubble.
- Read-after-write to the same word, issued in the cycle after the write ack: returns the new data.
- All outputs are registered; there is no combinational path from req_* or resp_ready to any output.

## Structure
- Shared package mem_if_pkg:
  - state enum (IDLE, WAIT, BURST, WACK)
  - LINE_WORDS/LATENCY defaults
  - function computing the wrapped word offset
- Sub-module mem_array: single-port, synchronous-read/synchronous-write word storage of DEPTH_WORDS. The responder FSM instantiates it once.

## Test plan
- Reset release, then write req_addr=0x10, wdata=0xDEADBEEF -> resp_valid exactly 4 cycles after accept; resp_last=1, resp_data=0, resp_word=0.
- Fill after writing words 0x00..0x0C = 1,2,3,4, req_addr=0x08 -> beats 3,4,1,2 with resp_word 2,3,0,1; resp_last only on 4th beat; 4 consecutive cycles.
- Same fill with resp_ready toggling 1,0,0,1,... -> data held across stalls, still 4 beats in order, no duplicates.
- req_valid held high during BURST -> req_ready=0, second request accepted only after last beat; its latency counted from its own accept.
- Address 0x1000 with DEPTH_WORDS=1024 -> aliases to word 0.
- rst pulled low mid-WAIT of a write to 0x20 -> outputs at reset values immediately; subsequent read of 0x20 returns old contents.
